uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter driven by an oversampling baud tick.
- The tick comes from the team's mod-M tick counter, which pulses s_tick once per M clk cycles.
- Accepts one parallel byte per request and emits start bit, DBIT data bits (LSB first), an optional parity bit and a stop period on the line `tx`.
- Sits in the UART top level beside the receiver. Both share one baud tick generator.

Parameters:
- DBIT, 8, number of data bits per frame (legal range 5..8).
- SB_TICK, 16, stop-period length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OVS, 16, s_tick pulses per start, data or parity bit (oversampling rate).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0).

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-high; clears all state.
- s_tick, input, 1, single-cycle oversampling tick (one clk wide).
- tx_start, input, 1, transmit request; sampled only in IDLE.
- din, input, DBIT, data to send; captured in the cycle tx_start is accepted.
- tx, output, 1, serial line; registered, idles high.
- tx_busy, output, 1, high whenever state != IDLE.
- tx_done_tick, output, 1, one-clk pulse at end of the stop period.

Behaviour:
- Reset values: state = IDLE, tx = 1, tx_busy = 0, tx_done_tick = 0, tick counter s = 0, bit counter n = 0, shift register b = 0, parity accumulator = 0.
- Reset mid-frame aborts the frame immediately and forces tx = 1 asynchronously. No partial-frame completion and no done pulse.
- States and transitions:
  - IDLE:
    - tx = 1.
    - If tx_start = 1 at a clk edge: b <= din, s <= 0, parity accumulator <= PARITY_ODD, go to START, tx <= 0 at the same edge.
    - Hence tx falls exactly 1 clk after the acceptance edge.
  - START:
    - On s_tick: if s == OVS-1, then s <= 0, n <= 0, go to DATA, tx <= b[0]; else s <= s+1.
  - DATA:
    - tx holds the current bit.
    - On s_tick with s == OVS-1: b <= b >> 1, parity accumulator ^= b[0], s <= 0.
    - If n == DBIT-1: go to PARITY (PARITY_EN = 1) or STOP; else n <= n+1 and tx <= next bit.
  - PARITY:
    - tx = final parity accumulator value.
    - On s_tick with s == OVS-1: go to STOP, tx <= 1.
  - STOP:
    - tx = 1.
    - On s_tick with s == SB_TICK-1: go to IDLE and assert tx_done_tick for exactly the next clk cycle.
- s_tick low: all counters and tx hold their values; clk cycles without a tick do nothing.
- Frame length in ticks: OVS*(1 + DBIT + PARITY_EN) + SB_TICK.
- tx_start outside IDLE is ignored, including in the cycle tx_done_tick is high. The earliest back-to-back acceptance is the first IDLE cycle, which coincides with tx_done_tick.
- din changes after acceptance have no effect on the frame in flight.
- Counter widths:
  - s is wide enough for max(OVS, SB_TICK)-1.
  - n is wide enough for DBIT-1.
  - All compares are unsigned and exact; no wrap past the terminal value.
- tx_busy = (state != IDLE), decoded from the registered state; it is high from the acceptance edge until the edge entering IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP; 3-bit);
  - default OVS = 16;
  - stop-length constants STOP_1 = 16, STOP_1P5 = 24, STOP_2 = 32.
  - The receiver uses the same package.
- No sub-module inside uart_tx: parity is a one-bit inline accumulator.
- The baud tick comes from the existing mod-M counter, instantiated at the UART top level (M = f_clk / (baud*OVS)) and wired to s_tick.

Test Plan:
- Reset release, no stimulus, 100 cycles -> tx = 1, tx_busy = 0, tx_done_tick = 0 throughout.
- Defaults, s_tick every cycle, din = 0x55, tx_start 1 cycle:
  - tx = 0 for 16 cycles, then bits 1,0,1,0,1,0,1,0 each 16 cycles, then 1 for 16 cycles;
  - tx_done_tick pulses once, 160 cycles after the acceptance edge;
  - tx_busy high for exactly 160 cycles.
- PARITY_EN = 1, PARITY_ODD = 0, din = 0x07:
  - parity bit = 1, frame 176 ticks.
  - With PARITY_ODD = 1 the parity bit = 0.
- s_tick every 4th cycle, din = 0xA3 -> frame spans 640 clk cycles; line pattern matches the 0xA3 LSB-first encoding; tx is stable between ticks.
- tx_start held high continuously with din = 0x01 then 0x02:
  - second byte is accepted only on the cycle tx_done_tick is high;
  - frames are contiguous with no idle gap beyond that 1 cycle;
  - din changes mid-frame are not transmitted.
- Assert reset during DATA bit 3 -> tx = 1 immediately, tx_busy = 0, no tx_done_tick. A new tx_start after release sends a complete, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling default and stop-length presets.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int unsigned OVS_DEFAULT = 16;

  localparam int unsigned STOP_1   = 16;
  localparam int unsigned STOP_1P5 = 24;
  localparam int unsigned STOP_2   = 32;

  // Bits needed for a counter that runs 0 .. max_val-1 (never narrower than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Request/line bundle between a UART transmitter and its user.
// The master drives the tick, start request and data; the slave returns the line and status.
interface uart_tx_if #(
  parameter int unsigned DBIT = 8
);
  logic            s_tick;
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output s_tick, tx_start, din,
    input  tx, tx_busy, tx_done_tick
  );

  modport slave (
    input  s_tick, tx_start, din,
    output tx, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity bit, stop period.
// All bit timing is counted in oversampling ticks; cycles without s_tick change nothing.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | sending start bit (low) for OVS ticks
// DATA   | sending data bits, LSB first, OVS ticks each
// PARITY | sending accumulated parity bit for OVS ticks
// STOP   | line high for SB_TICK ticks, then done pulse
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = STOP_1,
  parameter int unsigned OVS        = OVS_DEFAULT,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic      clk,
  input logic      reset,
  uart_tx_if.slave bus
);

  localparam int unsigned SW = cnt_width((OVS > SB_TICK) ? OVS : SB_TICK);
  localparam int unsigned NW = cnt_width(DBIT);

  localparam logic [SW-1:0] OVS_LAST  = SW'(OVS - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DBIT - 1);

  logic [2:0]      state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            par;
  logic            tx_reg;
  logic            done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s        <= '0;
      n        <= '0;
      b        <= '0;
      par      <= 1'b0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_start) begin
            b      <= bus.din;
            s      <= '0;
            par    <= 1'(PARITY_ODD);
            tx_reg <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s == OVS_LAST) begin
              s      <= '0;
              n      <= '0;
              tx_reg <= b[0];
              state  <= DATA;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s == OVS_LAST) begin
              s   <= '0;
              b   <= b >> 1;
              par <= par ^ b[0];
              if (n == BIT_LAST) begin
                // Parity must include the bit just finished, so fold it in here.
                if (PARITY_EN != 0) begin
                  tx_reg <= par ^ b[0];
                  state  <= PARITY;
                end else begin
                  tx_reg <= 1'b1;
                  state  <= STOP;
                end
              end else begin
                n      <= n + NW'(1);
                tx_reg <= b[1];
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        PARITY: begin
          if (bus.s_tick) begin
            if (s == OVS_LAST) begin
              s      <= '0;
              tx_reg <= 1'b1;
              state  <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if (s == STOP_LAST) begin
              s        <= '0;
              done_reg <= 1'b1;
              state    <= IDLE;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: begin
          tx_reg <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx           = tx_reg;
  assign bus.tx_busy      = (state != IDLE);
  assign bus.tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default, even/odd parity and slow-tick instances share
// the tick and data lines; each frame is checked tick-by-tick against its bit pattern.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       start;
  logic [7:0] din;
  int         sel;
  int         tick_div;
  int         ph;
  int         n_chk;
  int         n_err;

  logic tx_m, busy_m, done_m;

  uart_tx_if #(.DBIT(8)) bus0 ();
  uart_tx_if #(.DBIT(8)) bus_pe ();
  uart_tx_if #(.DBIT(8)) bus_po ();

  assign bus0.s_tick    = s_tick;
  assign bus_pe.s_tick  = s_tick;
  assign bus_po.s_tick  = s_tick;
  assign bus0.din       = din;
  assign bus_pe.din     = din;
  assign bus_po.din     = din;
  assign bus0.tx_start   = start && (sel == 0);
  assign bus_pe.tx_start = start && (sel == 1);
  assign bus_po.tx_start = start && (sel == 2);

  uart_tx u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_pe)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_po)
  );

  always_comb begin
    tx_m   = bus0.tx;
    busy_m = bus0.tx_busy;
    done_m = bus0.tx_done_tick;
    case (sel)
      1: begin
        tx_m   = bus_pe.tx;
        busy_m = bus_pe.tx_busy;
        done_m = bus_pe.tx_done_tick;
      end
      2: begin
        tx_m   = bus_po.tx;
        busy_m = bus_po.tx_busy;
        done_m = bus_po.tx_done_tick;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sets s_tick for the coming edge: every tick_div-th cycle.
  task automatic drive_tick();
    if (tick_div <= 1) begin
      s_tick = 1'b1;
    end else begin
      s_tick = (ph == tick_div - 1);
      ph     = (ph + 1) % tick_div;
    end
  endtask

  task automatic step();
    drive_tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame on instance s (unless already armed) and checks every cycle up to the done pulse.
  task automatic send_frame(input string tag, input int s, input logic [7:0] data,
                            input int pen, input logic pbit, input bit pre_armed,
                            input bit hold, input logic [7:0] din_after);
    logic [9:0] bits;
    int nb, total, budget, k;
    bit fin;
    nb    = 1 + 8 + pen;
    bits  = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (pen != 0) bits[9] = pbit;
    total = 16 * nb + 16;
    sel   = s;
    if (!pre_armed) begin
      din   = data;
      start = 1'b1;
      ph    = (tick_div > 1) ? tick_div - 1 : 0;
      drive_tick();
    end
    @(posedge clk);
    #1;
    start  = hold;
    din    = din_after;
    k      = 0;
    fin    = 1'b0;
    budget = total * tick_div + 8;
    for (int c = 0; c < budget && !fin; c++) begin
      if (k < total) begin
        check_eq({tag, "_tx"}, 32'(tx_m), (k < 16 * nb) ? 32'(bits[k/16]) : 32'd1);
        check_eq({tag, "_busy"}, 32'(busy_m), 32'd1);
        check_eq({tag, "_done"}, 32'(done_m), 32'd0);
        drive_tick();
        if (s_tick) k++;
        @(posedge clk);
        #1;
      end else begin
        check_eq({tag, "_end_tx"}, 32'(tx_m), 32'd1);
        check_eq({tag, "_end_busy"}, 32'(busy_m), 32'd0);
        check_eq({tag, "_end_done"}, 32'(done_m), 32'd1);
        check_eq({tag, "_len"}, 32'(c), 32'(total * tick_div));
        fin = 1'b1;
      end
    end
    if (!fin) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    din      = 8'h00;
    s_tick   = 1'b0;
    tick_div = 1;
    ph       = 0;
    sel      = 0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", 32'(bus0.tx), 32'd1);
    check_eq("rst_busy", 32'(bus0.tx_busy), 32'd0);
    check_eq("rst_done", 32'(bus0.tx_done_tick), 32'd0);
    check_eq("rst_pe_tx", 32'(bus_pe.tx), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      step();
      check_eq("idle", {29'd0, tx_m, busy_m, done_m}, 32'b100);
    end

    send_frame("f55", 0, 8'h55, 0, 1'b0, 1'b0, 1'b0, 8'hFF);
    step();
    check_eq("f55_done_one", 32'(done_m), 32'd0);

    send_frame("par_even", 1, 8'h07, 1, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    send_frame("par_odd", 2, 8'h07, 1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();

    tick_div = 4;
    send_frame("div4", 0, 8'hA3, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick_div = 1;
    step();

    // tx_start held through the frame; the second byte lands on the done cycle.
    send_frame("b2b_1", 0, 8'h01, 0, 1'b0, 1'b0, 1'b1, 8'h02);
    send_frame("b2b_2", 0, 8'h02, 0, 1'b0, 1'b1, 1'b0, 8'h04);
    step();
    check_eq("b2b_idle", {29'd0, tx_m, busy_m, done_m}, 32'b100);

    // Abort during data bit 3 of 0x55 (bit value 0).
    sel   = 0;
    din   = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (70) step();
    check_eq("pre_rst_tx", 32'(tx_m), 32'd0);
    check_eq("pre_rst_busy", 32'(busy_m), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("abort_tx", 32'(tx_m), 32'd1);
    check_eq("abort_busy", 32'(busy_m), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("abort_done", 32'(done_m), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("post_rst_idle", {29'd0, tx_m, busy_m, done_m}, 32'b100);
    end
    send_frame("after_rst", 0, 8'h3C, 0, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
